// File: rtl/pipe_alu_pkg.sv
// Shared opcode encodings and legality check for the pipelined ALU.
// Honours PIPE_ALU_MUL_EN: when undefined, the multiply opcode is treated as illegal.
package pipe_alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ASHR = 4'd8,
    OP_EQ   = 4'd9,
    OP_LTU  = 4'd10,
    OP_LTS  = 4'd11,
    OP_MUL  = 4'd12
  } alu_op_e;

  function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
`ifdef PIPE_ALU_MUL_EN
    return op <= OP_MUL;
`else
    return op <= OP_LTS;
`endif
  endfunction

endpackage

// File: rtl/pipe_alu_stage.sv
// One valid/ready register slice of the ALU pipeline: holds result, error flag and tag.
// The advance enable is computed by the parent from the downstream occupancy.
module pipe_alu_stage
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 adv,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_err,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [TAG_WIDTH-1:0] out_tag
);

  // Payload only loads on a real transaction so a drained slice keeps its last value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_err  <= in_err;
        out_tag  <= in_tag;
      end
    end
  end

endmodule

// File: rtl/pipe_alu.sv
// Pipelined integer ALU with valid/ready flow control and bubble collapsing.
// Define PIPE_ALU_MUL_EN to enable the multiply opcode; otherwise it reports an error.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0]     in_left,
  input  logic [WIDTH-1:0]     in_right,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int SHW = $clog2(WIDTH);

  logic signed [WIDTH-1:0] left_s;
  logic signed [WIDTH-1:0] right_s;
  logic [SHW-1:0]          shamt;
  logic [WIDTH-1:0]        res_p0;
  logic                    err_p0;

  assign left_s  = in_left;
  assign right_s = in_right;
  assign shamt   = in_right[SHW-1:0];

  // Stage 0 input: combinational result of the selected operation
  always_comb begin
    res_p0 = '0;
    err_p0 = 1'b0;
    if (!is_legal_op(in_op)) begin
      err_p0 = 1'b1;
    end else begin
      case (in_op)
        OP_ADD:  res_p0 = in_left + in_right;
        OP_SUB:  res_p0 = in_left - in_right;
        OP_AND:  res_p0 = in_left & in_right;
        OP_OR:   res_p0 = in_left | in_right;
        OP_XOR:  res_p0 = in_left ^ in_right;
        OP_NOT:  res_p0 = ~in_left;
        OP_SHL:  res_p0 = in_left << shamt;
        OP_SHR:  res_p0 = in_left >> shamt;
        OP_ASHR: res_p0 = left_s >>> shamt;
        OP_EQ:   res_p0 = {{(WIDTH-1){1'b0}}, in_left == in_right};
        OP_LTU:  res_p0 = {{(WIDTH-1){1'b0}}, in_left < in_right};
        OP_LTS:  res_p0 = {{(WIDTH-1){1'b0}}, left_s < right_s};
`ifdef PIPE_ALU_MUL_EN
        OP_MUL:  res_p0 = in_left * in_right;
`endif
        default: err_p0 = 1'b1;
      endcase
    end
  end

  logic [STAGES:0]        vld;
  logic [STAGES-1:0]      adv;
  logic [WIDTH-1:0]       dat [STAGES+1];
  logic                   err [STAGES+1];
  logic [TAG_WIDTH-1:0]   tag [STAGES+1];

  assign vld[0] = in_valid;
  assign dat[0] = res_p0;
  assign err[0] = err_p0;
  assign tag[0] = in_tag;

  // A slice advances when any slice at or after it is empty, or the consumer takes the
  // head; expressed over the registered valids so there is no combinational ready chain.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign adv[k] = out_ready || !(&vld[STAGES:k+1]);

    pipe_alu_stage #(
      .WIDTH     (WIDTH),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .adv       (adv[k]),
      .in_valid  (vld[k]),
      .in_data   (dat[k]),
      .in_err    (err[k]),
      .in_tag    (tag[k]),
      .out_valid (vld[k+1]),
      .out_data  (dat[k+1]),
      .out_err   (err[k+1]),
      .out_tag   (tag[k+1])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];
  assign out_err   = err[STAGES];
  assign out_tag   = tag[STAGES];

endmodule
